// File: rtl/uart_rx7to7.sv
// 7-bit UART receiver: start bit, 7 data bits LSB first, stop bit, no parity.
// States: IDLE wait for falling edge | START confirm mid start | DATA sample bits | STOP check stop | WAIT_HIGH wait for line release
module uart_rx7to7 #(
  parameter logic [12:0] DIV9600   = 13'd5208,
  parameter logic [12:0] DIV19200  = 13'd2603,
  parameter logic [12:0] DIV38400  = 13'd1301,
  parameter logic [12:0] DIV57600  = 13'd867,
  parameter logic [12:0] DIV115200 = 13'd434,
  parameter logic [12:0] DIV256000 = 13'd195
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] uart_ctl,
  input  logic       rs_rx,
  output logic [6:0] data_in,
  output logic       data_sign,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state;
  logic        sync1;
  logic        rx_s;
  logic        rx_d;
  logic [12:0] div;
  logic [12:0] div_sel;
  logic [12:0] cnt;
  logic [2:0]  bit_idx;
  logic [6:0]  shift;

  // Same code table as the transmitter; undefined codes fall back to 9600.
  always_comb begin
    case (uart_ctl)
      3'd1:    div_sel = DIV19200;
      3'd2:    div_sel = DIV38400;
      3'd3:    div_sel = DIV57600;
      3'd4:    div_sel = DIV115200;
      3'd5:    div_sel = DIV256000;
      default: div_sel = DIV9600;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rs_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= DIV9600;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_in   <= '0;
      data_sign <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      data_sign <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            div   <= div_sel;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == (div >> 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        DATA: begin
          if (cnt == div) begin
            shift   <= {rx_s, shift[6:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd6) state <= STOP;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (cnt == div) begin
            cnt <= '0;
            if (rx_s) begin
              data_in   <= shift;
              data_sign <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx7to7.sv
// Bench for uart_rx7to7: a serial line driver acts as the transmitter and a
// word/error queue model predicts what the receiver must report.
module tb_uart_rx7to7;
  // Slow codes are shortened so the run stays brief; the receiver only cares
  // that each code maps to its own bit period. Code 4 keeps its real value.
  localparam int D0 = 251;
  localparam int D1 = 199;
  localparam int D2 = 149;
  localparam int D3 = 101;
  localparam int D4 = 434;
  localparam int D5 = 195;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] uart_ctl = 3'd0;
  logic       rs_rx = 1'b1;
  logic [6:0] data_in;
  logic       data_sign;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_sign = 0;
  int n_ferr = 0;
  int n_both = 0;
  int t_sign = 0;
  int t_edge = 0;
  int exp_ferr = 0;
  logic [6:0] got_q[$];
  logic [6:0] exp_q[$];
  logic [6:0] last_good = 7'd0;

  uart_rx7to7 #(
    .DIV9600(13'(D0)), .DIV19200(13'(D1)), .DIV38400(13'(D2)),
    .DIV57600(13'(D3)), .DIV115200(13'(D4)), .DIV256000(13'(D5))
  ) dut (
    .clk(clk), .rst(rst), .uart_ctl(uart_ctl), .rs_rx(rs_rx),
    .data_in(data_in), .data_sign(data_sign), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_sign) begin
      got_q.push_back(data_in);
      n_sign++;
      t_sign = cyc;
    end
    if (frame_err) n_ferr++;
    if (data_sign && frame_err) n_both++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input logic [2:0] c);
    case (c)
      3'd1:    return D1;
      3'd2:    return D2;
      3'd3:    return D3;
      3'd4:    return D4;
      3'd5:    return D5;
      default: return D0;
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A low stop bit leaves the line low; the caller decides when it is released.
  task automatic send_frame(input logic [6:0] w, input logic [2:0] ctl, input logic stop,
                            input int chg_bit, input logic [2:0] chg_ctl);
    int len;
    len = div_of(ctl) + 1;
    uart_ctl = ctl;
    rs_rx = 1'b0;
    t_edge = cyc;
    wait_cyc(len);
    for (int i = 0; i < 7; i++) begin
      if (i == chg_bit) uart_ctl = chg_ctl;
      rs_rx = w[i];
      wait_cyc(len);
    end
    rs_rx = stop;
    wait_cyc(len);
    if (stop) begin
      exp_q.push_back(w);
      last_good = w;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    wait_cyc(4);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    chk({tag, "_ferr"}, n_ferr, exp_ferr);
    chk({tag, "_data_in"}, 32'(data_in), 32'(last_good));
  endtask

  initial begin
    int n0, f0, lat, explat, hold;
    logic [2:0] c;
    logic [6:0] w;
    logic st;

    wait_cyc(3);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_data_sign", 32'(data_sign), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Single frame at code 4 with latency measurement.
    n0 = n_sign;
    send_frame(7'h55, 3'd4, 1'b1, -1, 3'd0);
    lat = t_sign - t_edge;
    explat = 2 + 1 + D4 / 2 + 8 * (D4 + 1) + 1;
    chk("t1_latency", (lat >= explat - 2 && lat <= explat + 2) ? explat : lat, explat);
    chk("t1_sign_pulses", n_sign - n0, 1);
    settle("t1");

    // Back-to-back frames at every defined code.
    for (int k = 0; k < 6; k++) begin
      send_frame(7'h00, 3'(k), 1'b1, -1, 3'd0);
      send_frame(7'h7F, 3'(k), 1'b1, -1, 3'd0);
      send_frame(7'h2A, 3'(k), 1'b1, -1, 3'd0);
      settle($sformatf("loop%0d", k));
    end

    // Start glitch shorter than half a bit.
    uart_ctl = 3'd4;
    n0 = n_sign;
    rs_rx = 1'b0;
    wait_cyc(50);
    chk("glitch_busy", 32'(busy), 32'd1);
    wait_cyc(50);
    rs_rx = 1'b1;
    wait_cyc(130);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_sign", n_sign - n0, 0);
    chk("glitch_ferr", n_ferr, exp_ferr);
    send_frame(7'h11, 3'd4, 1'b1, -1, 3'd0);
    settle("glitch_next");

    // Low stop bit followed by a break.
    f0 = n_ferr;
    n0 = n_sign;
    send_frame(7'h3C, 3'd5, 1'b0, -1, 3'd0);
    wait_cyc(3 * (D5 + 1));
    rs_rx = 1'b1;
    wait_cyc(D5 + 1);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("ferr_no_sign", n_sign - n0, 0);
    settle("ferr");
    send_frame(7'h01, 3'd5, 1'b1, -1, 3'd0);
    settle("ferr_next");

    // uart_ctl changes mid-frame; the next frame uses the new code.
    send_frame(7'h4B, 3'd4, 1'b1, 3, 3'd0);
    send_frame(7'h35, 3'd0, 1'b1, -1, 3'd0);
    settle("ctlchg");

    // Reset pulse during data bit 3.
    w = 7'h5A;
    uart_ctl = 3'd4;
    rs_rx = 1'b0;
    wait_cyc(D4 + 1);
    for (int i = 0; i < 3; i++) begin
      rs_rx = w[i];
      wait_cyc(D4 + 1);
    end
    rs_rx = w[3];
    wait_cyc(200);
    n0 = n_sign;
    rst = 1'b1;
    wait_cyc(1);
    chk("mrst_data_in", 32'(data_in), 32'd0);
    chk("mrst_data_sign", 32'(data_sign), 32'd0);
    chk("mrst_frame_err", 32'(frame_err), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    rs_rx = 1'b1;
    last_good = 7'd0;
    wait_cyc(500);
    chk("mrst_no_sign", n_sign - n0, 0);
    send_frame(7'h66, 3'd5, 1'b1, -1, 3'd0);
    settle("mrst_next");

    // Random words, codes, stop bits and gaps.
    for (int k = 0; k < 8; k++) begin
      c = 3'($urandom_range(0, 7));
      if (c == 3'd4) c = 3'd5;
      w = 7'($urandom_range(0, 127));
      st = ($urandom_range(0, 3) != 0);
      send_frame(w, c, st, -1, 3'd0);
      if (!st) begin
        hold = $urandom_range(0, 2 * div_of(c));
        wait_cyc(hold);
        rs_rx = 1'b1;
        wait_cyc(div_of(c) + 1);
      end
      wait_cyc($urandom_range(0, 15));
    end
    settle("rand");
    chk("sign_and_ferr_overlap", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
